// File: rtl/dice_game_pkg.sv
// Shared types for the dice turn sequencer: die colour codes, turn FSM states
// and the colour-to-step mapping.
package dice_game_pkg;

  typedef enum logic [1:0] {
    C_NONE  = 2'b00,
    C_RED   = 2'b01,
    C_GREEN = 2'b10,
    C_BLUE  = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_DICE  = 3'd1,
    S_MOVE       = 3'd2,
    S_WAIT_CLEAR = 3'd3,
    S_NEXT       = 3'd4,
    S_WIN        = 3'd5
  } turn_state_t;

  function automatic logic [1:0] color_to_steps(input color_t c);
    case (c)
      C_RED:   return 2'd1;
      C_GREEN: return 2'd2;
      C_BLUE:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/step_tick_timer.sv
// Animation pacing counter: tick is high for one cycle every STEP_TICKS enabled cycles.
// Combinational tick off a registered count; clear has priority over en, no backpressure.
module step_tick_timer #(
  parameter int STEP_TICKS = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/dice_turn_sequencer.sv
// Turn controller: die colour -> step count, paced token advance, turn hand-off and win detection.
// First square moves STEP_TICKS cycles after the roll; pulses arriving in states that do not expect them are dropped.
module dice_turn_sequencer
  import dice_game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BOARD_LEN   = 30,
  parameter int STEP_TICKS  = 25000000,
  parameter int POS_W       = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_game,
  input  logic [1:0]                   stable_color,
  input  logic                         result_ready,
  input  logic                         turn_end,
  output logic [1:0]                   cur_player,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
  output logic [1:0]                   steps_left,
  output logic                         move_pulse,
  output logic [2:0]                   fsm_state,
  output logic                         game_over,
  output logic [1:0]                   winner
);

  localparam logic [POS_W-1:0] GOAL = POS_W'(BOARD_LEN - 1);

  turn_state_t      state;
  color_t           color;
  logic [POS_W-1:0] pos [NUM_PLAYERS];
  logic [POS_W-1:0] cur_pos;
  logic [POS_W-1:0] next_pos;
  logic             tick;

  assign color = color_t'(stable_color);

  always_comb begin
    cur_pos = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (cur_player == 2'(p)) cur_pos = pos[p];
    end
    next_pos = cur_pos + 1'b1;
  end

  // Counter is held at zero outside MOVE so every move starts a full period.
  step_tick_timer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step_tick_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state != S_MOVE),
    .en   (state == S_MOVE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_player <= '0;
      steps_left <= '0;
      move_pulse <= 1'b0;
      game_over  <= 1'b0;
      winner     <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) pos[p] <= '0;
    end else begin
      move_pulse <= 1'b0;
      case (state)
        S_IDLE, S_WIN: begin
          if (start_game) begin
            for (int p = 0; p < NUM_PLAYERS; p++) pos[p] <= '0;
            cur_player <= '0;
            winner     <= '0;
            game_over  <= 1'b0;
            state      <= S_WAIT_DICE;
          end
        end
        S_WAIT_DICE: begin
          if (result_ready && color != C_NONE) begin
            steps_left <= color_to_steps(color);
            state      <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (tick) begin
            move_pulse <= 1'b1;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (cur_player == 2'(p)) pos[p] <= next_pos;
            end
            // Reaching the goal ends the game; leftover steps are discarded.
            if (next_pos == GOAL) begin
              winner     <= cur_player;
              game_over  <= 1'b1;
              steps_left <= '0;
              state      <= S_WIN;
            end else begin
              steps_left <= steps_left - 2'd1;
              if (steps_left == 2'd1) state <= S_WAIT_CLEAR;
            end
          end
        end
        S_WAIT_CLEAR: begin
          if (turn_end) state <= S_NEXT;
        end
        S_NEXT: begin
          cur_player <= (cur_player == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cur_player + 2'd1;
          state      <= S_WAIT_DICE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) pos_flat[p*POS_W +: POS_W] = pos[p];
  end

  assign fsm_state = state;

endmodule
